chain_order_checker: RTL and testbench

Clocked Verilog-side checker that sits directly downstream of the shoelaced prsim/VPI inverter chain. It consumes the chain stimulus and every chain tap. For each stimulus edge it verifies a single wave that:
- propagates tap 0 to tap N_TAPS-1 in strict order,
- alternates polarity at each tap,
- completes within a bounded number of cycles.
It reports completed-wave count, worst-case latency and a sticky error with diagnosis. It replaces manual $monitor inspection in interleave regressions.

---
 rtl/chain_order_checker.sv | 232 +++++++++++++++++++++++
 tb/tb_chain_order_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chain_order_checker.sv
`default_nettype none
// ============================================================================
// Module   : chain_order_checker
// Brief    : Verifies that every stimulus edge produces one ordered, alternating,
//            latency-bounded wave through a sampled inverter chain.
// Revision : 1.0
// ============================================================================
module chain_order_checker #(
  parameter int N_TAPS  = 5,
  parameter int MAX_LAT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      src,
  input  logic [N_TAPS-1:0]         taps,
  output logic                      busy,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic [$clog2(N_TAPS)-1:0] err_tap,
  output logic [CNT_W-1:0]          wave_count,
  output logic [CNT_W-1:0]          max_lat
);

  localparam int C_TAP_W = $clog2(N_TAPS);
  localparam int C_PTR_W = $clog2(N_TAPS + 1);
  localparam int C_LAT_W = $clog2(MAX_LAT + 1);

  localparam logic [C_LAT_W-1:0] C_LAT_MAX     = C_LAT_W'(MAX_LAT);
  localparam logic [C_PTR_W-1:0] C_PTR_DONE    = C_PTR_W'(N_TAPS);
  localparam logic [1:0]         C_ERR_ORDER   = 2'd1;
  localparam logic [1:0]         C_ERR_TIMEOUT = 2'd2;
  localparam logic [1:0]         C_ERR_OVERRUN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  // Input synchronizers and previous-cycle copies for edge detection
  logic              src_sync1_q, src_sync2_q, src_prev_q;
  logic [N_TAPS-1:0] taps_sync1_q, taps_sync2_q, taps_prev_q;

  state_t             state_q, state_d;
  logic [C_PTR_W-1:0] ptr_q, ptr_d;
  logic               exp_q, exp_d;
  logic [C_LAT_W-1:0] lat_q, lat_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [C_TAP_W-1:0] err_tap_q, err_tap_d;
  logic [CNT_W-1:0]   wave_count_q, wave_count_d;
  logic [CNT_W-1:0]   max_lat_q, max_lat_d;

  logic               w_src_edge;
  logic [N_TAPS-1:0]  w_tap_edge;
  logic [N_TAPS-1:0]  w_run_mask;
  logic [C_PTR_W-1:0] w_run_len;
  logic               w_exp_next;
  logic [N_TAPS-1:0]  w_offend;
  logic [C_PTR_W-1:0] w_ptr_sum;
  logic               w_complete;
  logic [CNT_W-1:0]   w_lat_ext;

  function automatic logic [C_TAP_W-1:0] lowest_idx(input logic [N_TAPS-1:0] vec);
    logic [C_TAP_W-1:0] idx;
    idx = '0;
    for (int k = N_TAPS - 1; k >= 0; k--) begin
      if (vec[k]) idx = C_TAP_W'(k);
    end
    return idx;
  endfunction

  assign w_src_edge = src_sync2_q != src_prev_q;
  assign w_tap_edge = taps_sync2_q ^ taps_prev_q;

  // Accept the longest run of edging taps from ptr whose values keep alternating
  always_comb begin : p_run
    logic run_on;
    logic pol;
    w_run_mask = '0;
    w_run_len  = '0;
    run_on     = 1'b1;
    pol        = exp_q;
    for (int k = 0; k < N_TAPS; k++) begin
      if (run_on && (k >= int'(ptr_q))) begin
        if (w_tap_edge[k] && (taps_sync2_q[k] == pol)) begin
          w_run_mask[k] = 1'b1;
          w_run_len     = w_run_len + C_PTR_W'(1);
          pol           = ~pol;
        end else begin
          run_on = 1'b0;
        end
      end
    end
    w_exp_next = pol;
  end

  assign w_offend   = w_tap_edge & ~w_run_mask;
  assign w_ptr_sum  = ptr_q + w_run_len;
  assign w_complete = w_ptr_sum == C_PTR_DONE;
  assign w_lat_ext  = CNT_W'(lat_q);

  always_comb begin : p_fsm
    state_d      = state_q;
    ptr_d        = ptr_q;
    exp_d        = exp_q;
    lat_d        = lat_q;
    err_d        = err_q;
    err_code_d   = err_code_q;
    err_tap_d    = err_tap_q;
    wave_count_d = wave_count_q;
    max_lat_d    = max_lat_q;

    if (clear) begin
      state_d      = S_IDLE;
      err_d        = 1'b0;
      err_code_d   = '0;
      err_tap_d    = '0;
      wave_count_d = '0;
      max_lat_d    = '0;
    end else if (!en) begin
      if (state_q != S_ERROR) state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_src_edge) begin
            state_d = S_TRACK;
            ptr_d   = '0;
            exp_d   = ~src_sync2_q;
            lat_d   = C_LAT_W'(1);
          end else if (|w_tap_edge) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = C_ERR_ORDER;
            err_tap_d  = lowest_idx(w_tap_edge);
          end
        end
        S_TRACK: begin
          lat_d = (lat_q == C_LAT_MAX) ? lat_q : lat_q + C_LAT_W'(1);
          if (|w_offend) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = C_ERR_ORDER;
            err_tap_d  = lowest_idx(w_offend);
          end else if (w_complete) begin
            if (wave_count_q != '1) wave_count_d = wave_count_q + CNT_W'(1);
            if (w_lat_ext > max_lat_q) max_lat_d = w_lat_ext;
            if (w_src_edge) begin
              ptr_d = '0;
              exp_d = ~src_sync2_q;
              lat_d = C_LAT_W'(1);
            end else begin
              state_d = S_IDLE;
            end
          end else if (w_src_edge) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = C_ERR_OVERRUN;
            err_tap_d  = '0;
          end else if (lat_q == C_LAT_MAX) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = C_ERR_TIMEOUT;
            err_tap_d  = '0;
          end else begin
            ptr_d = w_ptr_sum;
            exp_d = w_exp_next;
          end
        end
        S_ERROR: begin
          state_d = S_ERROR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = state_d == S_TRACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_sync1_q  <= 1'b0;
      src_sync2_q  <= 1'b0;
      src_prev_q   <= 1'b0;
      taps_sync1_q <= '0;
      taps_sync2_q <= '0;
      taps_prev_q  <= '0;
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      exp_q        <= 1'b0;
      lat_q        <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
      err_tap_q    <= '0;
      wave_count_q <= '0;
      max_lat_q    <= '0;
    end else begin
      src_sync1_q  <= src;
      src_sync2_q  <= src_sync1_q;
      src_prev_q   <= src_sync2_q;
      taps_sync1_q <= taps;
      taps_sync2_q <= taps_sync1_q;
      taps_prev_q  <= taps_sync2_q;
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      exp_q        <= exp_d;
      lat_q        <= lat_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
      err_tap_q    <= err_tap_d;
      wave_count_q <= wave_count_d;
      max_lat_q    <= max_lat_d;
    end
  end

  assign busy       = busy_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_tap    = err_tap_q;
  assign wave_count = wave_count_q;
  assign max_lat    = max_lat_q;

endmodule
`default_nettype wire

// File: tb/tb_chain_order_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_chain_order_checker
// Brief    : Directed-vector bench for chain_order_checker (N_TAPS=5, MAX_LAT=16).
// Revision : 1.0
// ============================================================================
module tb_chain_order_checker;

  localparam int N_TAPS  = 5;
  localparam int MAX_LAT = 16;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              clear;
  logic              src;
  logic [N_TAPS-1:0] taps;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;
  logic [2:0]        err_tap;
  logic [CNT_W-1:0]  wave_count;
  logic [CNT_W-1:0]  max_lat;

  int n_checks  = 0;
  int n_bad     = 0;
  int busy_seen = 0;

  always #5 clk = ~clk;

  chain_order_checker #(
    .N_TAPS (N_TAPS),
    .MAX_LAT(MAX_LAT),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .src       (src),
    .taps      (taps),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code),
    .err_tap   (err_tap),
    .wave_count(wave_count),
    .max_lat   (max_lat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
    end
  endtask

  task automatic tog(input int k);
    taps[k] = ~taps[k];
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);
  endtask

  // src edge, then taps 0..N-1 one cycle apart
  task automatic clean_wave();
    src = ~src;
    for (int k = 0; k < N_TAPS; k++) begin
      cyc(1);
      tog(k);
    end
    cyc(4);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clear = 1'b0;
    src   = 1'b0;
    taps  = 5'b10101;
    cyc(3);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_code", 32'(err_code), 32'd0);
    check_eq("rst_wc", 32'(wave_count), 32'd0);
    check_eq("rst_maxlat", 32'(max_lat), 32'd0);

    // Let the synchronizers absorb the initial chain state while disabled
    rst_n = 1'b1;
    cyc(4);
    en = 1'b1;
    cyc(2);
    check_eq("settle_err", 32'(err), 32'd0);

    // Clean wave
    busy_seen = 0;
    clean_wave();
    check_eq("clean_wc", 32'(wave_count), 32'd1);
    check_eq("clean_maxlat", 32'(max_lat), 32'd5);
    check_eq("clean_err", 32'(err), 32'd0);
    check_eq("clean_busy_now", 32'(busy), 32'd0);
    check_eq("clean_busy_cycles", 32'(busy_seen), 32'd5);

    // Tap 1 before tap 0
    src = ~src;
    cyc(1);
    tog(1);
    cyc(4);
    check_eq("swap_err", 32'(err), 32'd1);
    check_eq("swap_code", 32'(err_code), 32'd1);
    check_eq("swap_tap", 32'(err_tap), 32'd1);
    tog(0); tog(2); tog(3); tog(4);
    cyc(4);
    clean_wave();
    check_eq("swap_wc_kept", 32'(wave_count), 32'd1);
    check_eq("swap_err_sticky", 32'(err), 32'd1);

    do_clear();
    check_eq("clr_err", 32'(err), 32'd0);
    check_eq("clr_code", 32'(err_code), 32'd0);
    check_eq("clr_wc", 32'(wave_count), 32'd0);
    check_eq("clr_maxlat", 32'(max_lat), 32'd0);

    // Timeout: taps 3..4 stall
    src = ~src;
    cyc(1); tog(0);
    cyc(1); tog(1);
    cyc(1); tog(2);
    cyc(15);
    check_eq("tmo_not_yet", 32'(err), 32'd0);
    cyc(1);
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_code", 32'(err_code), 32'd2);
    check_eq("tmo_tap", 32'(err_tap), 32'd0);
    tog(3); tog(4);
    cyc(4);
    do_clear();

    // Overrun: second src edge with ptr at 2
    src = ~src;
    cyc(1); tog(0);
    cyc(1); tog(1);
    cyc(1); src = ~src;
    cyc(5);
    check_eq("ovr_err", 32'(err), 32'd1);
    check_eq("ovr_code", 32'(err_code), 32'd3);
    check_eq("ovr_tap", 32'(err_tap), 32'd0);
    tog(0); tog(1);
    cyc(4);
    do_clear();

    // Back-to-back: new src edge coincident with the last tap edge
    src = ~src;
    for (int k = 0; k < N_TAPS - 1; k++) begin
      cyc(1);
      tog(k);
    end
    cyc(1);
    tog(N_TAPS - 1);
    src = ~src;
    for (int k = 0; k < N_TAPS; k++) begin
      cyc(1);
      tog(k);
    end
    cyc(4);
    check_eq("b2b_wc", 32'(wave_count), 32'd2);
    check_eq("b2b_err", 32'(err), 32'd0);
    check_eq("b2b_maxlat", 32'(max_lat), 32'd5);

    // Coarse sampling: all taps in one sampled cycle
    do_clear();
    src = ~src;
    cyc(1);
    taps = ~taps;
    cyc(4);
    check_eq("coarse_wc", 32'(wave_count), 32'd1);
    check_eq("coarse_maxlat", 32'(max_lat), 32'd1);
    check_eq("coarse_err", 32'(err), 32'd0);

    // Same, tap 2 missing
    src = ~src;
    cyc(1);
    taps = taps ^ 5'b11011;
    cyc(4);
    check_eq("gap_err", 32'(err), 32'd1);
    check_eq("gap_code", 32'(err_code), 32'd1);
    check_eq("gap_tap", 32'(err_tap), 32'd3);
    tog(2);
    cyc(4);
    do_clear();

    // Asynchronous reset mid-wave
    clean_wave();
    src = ~src;
    cyc(1); tog(0);
    cyc(3);
    check_eq("prerst_busy", 32'(busy), 32'd1);
    check_eq("prerst_wc", 32'(wave_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_wc", 32'(wave_count), 32'd0);
    check_eq("arst_maxlat", 32'(max_lat), 32'd0);

    // Disabled: spurious tap edges must be ignored
    en = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1); tog(3);
    cyc(1); tog(1); tog(4);
    cyc(1); tog(3);
    cyc(1); tog(3); tog(2);
    cyc(4);
    check_eq("dis_err", 32'(err), 32'd0);
    check_eq("dis_wc", 32'(wave_count), 32'd0);
    check_eq("dis_busy", 32'(busy), 32'd0);

    // Wave abandoned by deasserting en mid-flight
    en = 1'b1;
    cyc(2);
    src = ~src;
    cyc(1); tog(0);
    cyc(1); tog(1);
    cyc(2);
    check_eq("abn_busy", 32'(busy), 32'd1);
    en = 1'b0;
    tog(2); tog(3); tog(4);
    cyc(5);
    en = 1'b1;
    cyc(3);
    check_eq("abn_err", 32'(err), 32'd0);
    check_eq("abn_wc", 32'(wave_count), 32'd0);
    clean_wave();
    check_eq("reen_wc", 32'(wave_count), 32'd1);
    check_eq("reen_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
